// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic MIPS pipeline stages:
//   - control/data bundle widths of each inter-stage register
//   - field offsets of the EX/MEM data bundle plus a pack helper
//   - the stage state encoding (EMPTY / ONE / TWO entries held)
// ---------------------------------------------------------------------------
package pipe_pkg;

  // Bundle widths per stage boundary.
  localparam int IDEX_CTRL_W  = 12;
  localparam int IDEX_DATA_W  = 111;  // rs,rt,rd (15) + busA,busB,imm32 (96)
  localparam int EXMEM_CTRL_W = 10;
  localparam int EXMEM_DATA_W = 79;   // rs,rt,rd (15) + busB (32) + Result (32)
  localparam int MEMWB_CTRL_W = 3;
  localparam int MEMWB_DATA_W = 69;   // rd (5) + mem data (32) + Result (32)

  // EX/MEM data bundle field offsets (LSB positions).
  localparam int EXMEM_RESULT_LSB = 0;
  localparam int EXMEM_BUSB_LSB   = 32;
  localparam int EXMEM_RD_LSB     = 64;
  localparam int EXMEM_RT_LSB     = 69;
  localparam int EXMEM_RS_LSB     = 74;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  // Number of entries held in a given state; the unused encoding reports 0.
  function automatic logic [1:0] state_occupancy(input stage_state_t st);
    case (st)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [EXMEM_DATA_W-1:0] exmem_pack(
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [31:0] bus_b,
    input logic [31:0] result
  );
    return {rs, rt, rd, bus_b, result};
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic_if
// Valid/ready beat channel carrying a control bundle and a data bundle.
//   valid : producer has a beat          ready : consumer accepts it
//   ctrl  : control bundle (CTRL_W)      data  : data bundle (DATA_W)
// master = producer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface pipe_stage_elastic_if #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 79
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, ctrl, data, input ready);
  modport slave  (input valid, ctrl, data, output ready);
endinterface

// File: rtl/pipe_entry_reg.sv
// ---------------------------------------------------------------------------
// pipe_entry_reg
// One pipeline entry: valid flag + control + data register.
//   clk, rst     : clock, synchronous active-high reset (clears everything)
//   load_i       : capture ctrl_i/data_i and set valid
//   clr_i        : drop the entry (valid and ctrl to 0); wins over load_i
//   clr_data_i   : with clr_i, also zero the data register
//   valid_o/ctrl_o/data_o : registered contents
// ---------------------------------------------------------------------------
module pipe_entry_reg #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 79
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic              clr_data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // NOTE: registers update with non-blocking (<=) so every flop samples
  // pre-edge values; data is reset as well so out_data reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      if (clr_data_i) data_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
// Elastic pipeline stage between two MIPS stages, 1-clk latency, FIFO order.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : drop every held entry (and any beat arriving this cycle)
//   stall      : freeze; no beat in or out this cycle
//   in_if      : upstream beat channel (slave)
//   out_if     : downstream beat channel (master); ctrl is 0 on bubbles
//   occupancy  : entries held (0..2)
// SKID=0: single head entry, in_ready follows out_ready combinationally.
// SKID=1: head + skid entry, in_ready depends only on local state.
// FLUSH_DATA=1: flush also zeroes the data registers.
// ---------------------------------------------------------------------------
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = EXMEM_CTRL_W,
  parameter int DATA_W     = EXMEM_DATA_W,
  parameter int SKID       = 1,
  parameter int FLUSH_DATA = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 stall,
  pipe_stage_elastic_if.slave  in_if,
  pipe_stage_elastic_if.master out_if,
  output logic [1:0]           occupancy
);
  stage_state_t      state_q, state_d;
  logic              h_valid, s_valid;
  logic [CTRL_W-1:0] h_ctrl, s_ctrl, h_ctrl_d;
  logic [DATA_W-1:0] h_data, s_data, h_data_d;
  logic              h_load, h_clr, h_clr_data, h_from_s;
  logic              s_load, s_clr, s_clr_data;
  logic              in_fire, out_fire;

  assign in_fire  = in_if.valid & in_if.ready;
  assign out_fire = out_if.valid & out_if.ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Priority: flush > illegal-state recovery > stall > handshake.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal (no latches).
    state_d    = state_q;
    h_load     = 1'b0;
    h_clr      = 1'b0;
    h_clr_data = 1'b0;
    h_from_s   = 1'b0;
    s_load     = 1'b0;
    s_clr      = 1'b0;
    s_clr_data = 1'b1;
    if (flush) begin
      state_d    = ST_EMPTY;
      h_clr      = 1'b1;
      s_clr      = 1'b1;
      h_clr_data = (FLUSH_DATA != 0);
      s_clr_data = (FLUSH_DATA != 0);
    end else if (!(state_q inside {ST_EMPTY, ST_ONE, ST_TWO})) begin
      state_d = ST_EMPTY;
      h_clr   = 1'b1;
      s_clr   = 1'b1;
    end else if (!stall) begin
      case (state_q)
        ST_EMPTY: if (in_fire) begin
          state_d = ST_ONE;
          h_load  = 1'b1;
        end
        ST_ONE: if (in_fire) begin
          // Without a skid entry in_fire in ONE implies out_fire: reload head.
          if (out_fire || SKID == 0) begin
            h_load = 1'b1;
          end else begin
            s_load  = 1'b1;
            state_d = ST_TWO;
          end
        end else if (out_fire) begin
          state_d = ST_EMPTY;
          h_clr   = 1'b1;  // data kept: out_data keeps showing the last head
        end
        ST_TWO: if (out_fire) begin
          state_d  = ST_ONE;
          h_load   = 1'b1;
          h_from_s = 1'b1;
          s_clr    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign h_ctrl_d = h_from_s ? s_ctrl : in_if.ctrl;
  assign h_data_d = h_from_s ? s_data : in_if.data;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
    .clk        (clk),
    .rst        (rst),
    .load_i     (h_load),
    .clr_i      (h_clr),
    .clr_data_i (h_clr_data),
    .ctrl_i     (h_ctrl_d),
    .data_i     (h_data_d),
    .valid_o    (h_valid),
    .ctrl_o     (h_ctrl),
    .data_o     (h_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load_i     (s_load),
        .clr_i      (s_clr),
        .clr_data_i (s_clr_data),
        .ctrl_i     (in_if.ctrl),
        .data_i     (in_if.data),
        .valid_o    (s_valid),
        .ctrl_o     (s_ctrl),
        .data_o     (s_data)
      );
      // Registered-only ready: no combinational path from out_ready.
      assign in_if.ready = ~rst & ~stall & ~s_valid & (state_q inside {ST_EMPTY, ST_ONE});
    end else begin : g_pass
      logic unused_skid_ctl;
      assign s_valid         = 1'b0;
      assign s_ctrl          = '0;
      assign s_data          = '0;
      assign unused_skid_ctl = ^{s_load, s_clr, s_clr_data};
      assign in_if.ready = ~rst & ~stall &
                           ((state_q == ST_EMPTY) | ((state_q == ST_ONE) & out_if.ready));
    end
  endgenerate

  assign out_if.valid = ~rst & ~stall & h_valid;
  assign out_if.ctrl  = out_if.valid ? h_ctrl : '0;
  assign out_if.data  = rst ? '0 : h_data;
  assign occupancy    = rst ? 2'd0 : state_occupancy(state_q);
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_elastic
// Drives a SKID=1/FLUSH_DATA=0 stage and a SKID=0/FLUSH_DATA=1 stage with the
// same inputs. Each stage has a queue-based reference model: the queue holds
// the accepted beats, its size is the occupancy and its front is the head.
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic;
  localparam int CW = 10;
  localparam int DW = 79;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst, flush, stall, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic [1:0]    occ_s, occ_p;

  always #5 clk = ~clk;

  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) s_in ();
  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) s_out ();
  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) p_in ();
  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) p_out ();

  assign s_in.valid  = in_valid;
  assign s_in.ctrl   = in_ctrl;
  assign s_in.data   = in_data;
  assign s_out.ready = out_ready;
  assign p_in.valid  = in_valid;
  assign p_in.ctrl   = in_ctrl;
  assign p_in.data   = in_data;
  assign p_out.ready = out_ready;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .FLUSH_DATA(0)) dut_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall     (stall),
    .in_if     (s_in),
    .out_if    (s_out),
    .occupancy (occ_s)
  );

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .FLUSH_DATA(1)) dut_pass (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall     (stall),
    .in_if     (p_in),
    .out_if    (p_out),
    .occupancy (occ_p)
  );

  // Reference model state, index 0 = skid stage, 1 = pass-through stage.
  beat_t         q[2][$];
  logic [DW-1:0] last_head[2];
  logic [DW-1:0] obs[2][$];     // data of beats seen leaving each stage
  bit            in_fire_m[2];
  bit            out_fire_m[2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic eval_dut(input int d, input logic rdy, input logic vld,
                          input logic [CW-1:0] ctl, input logic [DW-1:0] dat,
                          input logic [1:0] occ);
    string         nm;
    int            n;
    bit            exp_rdy, exp_vld;
    logic [CW-1:0] exp_ctl;
    logic [DW-1:0] exp_dat;
    logic [1:0]    exp_occ;
    nm      = (d == 0) ? "skid" : "pass";
    n       = q[d].size();
    exp_rdy = !rst && !stall && ((d == 0) ? (n < 2) : (n == 0 || out_ready));
    exp_vld = !rst && !stall && (n > 0);
    exp_ctl = exp_vld ? q[d][0].ctrl : '0;
    exp_dat = rst ? '0 : ((n > 0) ? q[d][0].data : last_head[d]);
    exp_occ = rst ? 2'd0 : 2'(n);
    check({nm, ".in_ready"},  {127'd0, rdy}, {127'd0, exp_rdy});
    check({nm, ".out_valid"}, {127'd0, vld}, {127'd0, exp_vld});
    check({nm, ".out_ctrl"},  128'(ctl), 128'(exp_ctl));
    check({nm, ".out_data"},  128'(dat), 128'(exp_dat));
    check({nm, ".occupancy"}, 128'(occ), 128'(exp_occ));
    in_fire_m[d]  = in_valid && exp_rdy;
    out_fire_m[d] = exp_vld && out_ready;
    if (vld && out_ready) obs[d].push_back(dat);
  endtask

  // One clock: drive on the falling edge, check 1 time unit later, then
  // advance the models at the rising edge using the values just driven.
  task automatic cycle(input logic r, input logic f, input logic s, input logic iv,
                       input logic [CW-1:0] ic, input logic [DW-1:0] id, input logic ordy);
    beat_t b;
    @(negedge clk);
    rst = r; flush = f; stall = s; in_valid = iv;
    in_ctrl = ic; in_data = id; out_ready = ordy;
    #1;
    eval_dut(0, s_in.ready, s_out.valid, s_out.ctrl, s_out.data, occ_s);
    eval_dut(1, p_in.ready, p_out.valid, p_out.ctrl, p_out.data, occ_p);
    @(posedge clk);
    b.ctrl = ic;
    b.data = id;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        q[d].delete();
        last_head[d] = '0;
      end else if (f) begin
        q[d].delete();
        if (d == 1) last_head[d] = '0;   // pass stage flushes data too
      end else if (!s) begin
        if (out_fire_m[d]) void'(q[d].pop_front());
        if (in_fire_m[d]) q[d].push_back(b);
        if (q[d].size() > 0) last_head[d] = q[d][0].data;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, ordy);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b1;
    in_ctrl = '0; in_data = '0; out_ready = 1'b1;
    last_head[0] = '0;
    last_head[1] = '0;

    // 1: reset with in_valid held high
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 10'h3FF, DW'(32'h99), 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 10'h3FF, DW'(32'h99), 1'b1);
    idle(1'b1);

    // 2: streaming 1..8 with downstream always ready
    obs[0].delete(); obs[1].delete();
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h3FF, DW'(i), 1'b1);
    idle(1'b1); idle(1'b1);
    check("stream.count_skid", 128'(obs[0].size()), 128'd8);
    check("stream.count_pass", 128'(obs[1].size()), 128'd8);
    for (int i = 0; i < obs[0].size(); i++) check("stream.order_skid", 128'(obs[0][i]), 128'(i + 1));
    for (int i = 0; i < obs[1].size(); i++) check("stream.order_pass", 128'(obs[1][i]), 128'(i + 1));

    // 3: backpressure on the skid stage, A,B accepted, C held
    obs[0].delete(); obs[1].delete();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h00A, DW'(32'hA), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h00B, DW'(32'hB), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h00C, DW'(32'hC), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h00C, DW'(32'hC), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h00C, DW'(32'hC), 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h00C, DW'(32'hC), 1'b1);
    idle(1'b1); idle(1'b1);
    check("bp.count_skid", 128'(obs[0].size()), 128'd3);
    for (int i = 0; i < obs[0].size(); i++) check("bp.order_skid", 128'(obs[0][i]), 128'(32'hA + i));

    // 4: flush and stall together with a full skid stage and a new beat
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h011, DW'(32'h11), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h022, DW'(32'h22), 1'b0);
    obs[0].delete(); obs[1].delete();
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 10'h044, DW'(32'h44), 1'b0);
    idle(1'b1); idle(1'b1);
    check("flush.no_beat_skid", 128'(obs[0].size()), 128'd0);
    check("flush.no_beat_pass", 128'(obs[1].size()), 128'd0);

    // 5: stall holding 0xDEADBEEF with downstream ready
    obs[0].delete(); obs[1].delete();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h155, DW'(32'hDEADBEEF), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
    idle(1'b1); idle(1'b1);
    check("stall.count_skid", 128'(obs[0].size()), 128'd1);
    check("stall.count_pass", 128'(obs[1].size()), 128'd1);
    if (obs[0].size() > 0) check("stall.data_skid", 128'(obs[0][0]), 128'(32'hDEADBEEF));
    if (obs[1].size() > 0) check("stall.data_pass", 128'(obs[1][0]), 128'(32'hDEADBEEF));

    // 6: pass-through replace while full, no bubble
    obs[0].delete(); obs[1].delete();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h061, DW'(32'h61), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h062, DW'(32'h62), 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h063, DW'(32'h63), 1'b1);
    idle(1'b1); idle(1'b1);
    check("pt.count_pass", 128'(obs[1].size()), 128'd3);
    for (int i = 0; i < obs[1].size(); i++) check("pt.order_pass", 128'(obs[1][i]), 128'(32'h61 + i));

    // Randomized traffic against the models
    for (int k = 0; k < 800; k++) begin
      cycle($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(7) == 0,
            1'($urandom_range(1)), CW'($urandom), DW'({$urandom, $urandom, $urandom}),
            $urandom_range(99) < 60);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
